x_mac_array: RTL
================

Name: x_mac_array

Overview:
- Downstream consumer of the X shift buffer.
- Takes the four 8-bit X lane outputs, a stored 4x8 matrix with 8 bytes per lane, and multiplies them against an 8x4 coefficient matrix read from a synchronous ROM.
- Produces one 4-element result column per pass, 4 columns in total.
- Drives X_shift back to the buffer and hands each column to the output/storage stage with a valid/ready handshake.

Parameters:
- DATA_W, 8, width of X bytes and coefficients (unsigned).
- N_K, 8, inner-product length; also the number of X_shift pulses per column.
- N_COL, 4, number of result columns.
- ACC_W, 19, accumulator/result width; equals 2*DATA_W+clog2(N_K), so there is no overflow.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin a full 4-column computation.
- xload_done  in  1  X buffer fully loaded.
- X_reg1..X_reg4  in  8 each  current head byte of each X lane.
- X_shift  out  1  rotate the X buffer by one byte.
- coef_addr  out  5  ROM address {col[1:0], k[2:0]}.
- coef_data  in  8  ROM data, valid 1 cycle after coef_addr.
- result1..result4  out  19 each  accumulated column results, one per X lane.
- result_valid  out  1  results are stable and valid.
- result_ready  in  1  consumer accepts the results.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse after the last column is accepted.

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE; col=0; k=0.
  - X_shift=0, coef_addr=0.
  - result1..4=0, result_valid=0, busy=0, done=0.
  - pipeline valid flag cleared.
- Reset mid-operation abandons the computation; no partial result is ever presented.
- FSM states: IDLE, MAC, DRAIN, OUT, FIN.
- IDLE:
  - start && xload_done → MAC, with col=0, k=0.
  - start while xload_done=0 is ignored.
  - start outside IDLE is ignored.
- MAC: lasts exactly N_K cycles. Each cycle:
  - X_shift=1 and coef_addr={col,k}.
  - Stage-1 registers capture X_reg1..4 and p_valid=1, plus first=(k==0).
  - k increments; at k==N_K-1 the FSM goes to DRAIN and k wraps to 0.
- Stage 2 (every cycle p_valid=1):
  - product_i = x_q_i * coef_data, 16-bit unsigned.
  - acc_i <= first ? product_i : acc_i + product_i, zero-extended to ACC_W.
- DRAIN:
  - 1 cycle; X_shift=0.
  - The last product is accumulated this cycle; then the FSM goes to OUT.
- OUT:
  - result_i = acc_i; result_valid=1; X_shift=0.
  - Results are held stable until result_ready=1.
  - On a cycle with result_valid && result_ready:
    - if col==N_COL-1 → FIN;
    - otherwise col++ and → MAC.
- FIN: done=1 for one cycle; then → IDLE with busy=0.
- result1..4 keep their last value after FIN; result_valid=0 outside OUT.
- X buffer alignment: exactly N_K shifts per column. The 64-bit lanes rotate back to their original byte order at the start of every column, so every column sees X[k] for k=0..7 in order.
- Latency and throughput (start accepted at edge 0):
  - MAC occupies cycles 1-8; DRAIN is cycle 9; result_valid rises at cycle 10.
  - With result_ready tied high, each column takes 10 cycles, so the full run is 40 cycles plus 1 FIN cycle.
- result_ready asserted outside OUT has no effect.
- No arithmetic saturation is needed, because ACC_W covers 8*255*255=520200.

Test Plan:
- All X bytes=1 and all coefficients=1; start with xload_done=1 → 4 handshakes, each with result1..4=8; done pulses once; exactly 32 X_shift pulses in total.
- All X=255, all coef=255 → every result=520200 (0x7F008); no wrap.
- Identity-like ROM, C[k][j]=(k==j), with X lane i byte k = 16*i+k → column j gives result_i = 16*i+j.
- result_ready held low for 5 cycles in OUT of column 1 → results stable, result_valid high, X_shift=0 and coef_addr unchanged; after ready rises, column 2 starts on the next cycle.
- start pulsed with xload_done=0 → stays IDLE, busy=0, X_shift never asserts; start again during MAC → ignored, sequence unchanged.
- rst asserted during MAC of column 2 → all outputs 0 immediately; a new start produces correct results from column 0.

Source files
------------

// File: rtl/x_mac_array.sv
// x_mac_array: multiplies the four X shift-buffer lanes (8 bytes each)
// against an 8x4 coefficient matrix held in an external synchronous ROM.
// One 4-element result column is produced per pass, N_COL passes per run.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start with the X buffer loaded
// MAC   | N_K cycles: shift X, address ROM, feed the multiply pipeline
// DRAIN | last product lands in the accumulators, results captured
// OUT   | results presented with result_valid until result_ready
// FIN   | one-cycle done pulse, then back to IDLE
module x_mac_array #(
  parameter int DATA_W = 8,
  parameter int N_K    = 8,
  parameter int N_COL  = 4,
  parameter int ACC_W  = 19
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  xload_done,
  input  logic [DATA_W-1:0]                     X_reg1,
  input  logic [DATA_W-1:0]                     X_reg2,
  input  logic [DATA_W-1:0]                     X_reg3,
  input  logic [DATA_W-1:0]                     X_reg4,
  output logic                                  X_shift,
  output logic [$clog2(N_COL)+$clog2(N_K)-1:0]  coef_addr,
  input  logic [DATA_W-1:0]                     coef_data,
  output logic [ACC_W-1:0]                      result1,
  output logic [ACC_W-1:0]                      result2,
  output logic [ACC_W-1:0]                      result3,
  output logic [ACC_W-1:0]                      result4,
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic                                  busy,
  output logic                                  done
);

  localparam int COL_W = $clog2(N_COL);
  localparam int K_W   = $clog2(N_K);
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [K_W-1:0]   LAST_K   = K_W'(N_K - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COL - 1);

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, OUT, FIN} state_t;

  state_t             state;
  logic [COL_W-1:0]   col;
  logic [K_W-1:0]     k;

  logic [DATA_W-1:0]  x_in   [4];
  logic [DATA_W-1:0]  x_q    [4];
  logic               p_valid;
  logic               first_q;

  logic [PROD_W-1:0]  prod     [4];
  logic [ACC_W-1:0]   acc      [4];
  logic [ACC_W-1:0]   acc_next [4];
  logic [ACC_W-1:0]   res_q    [4];

  assign x_in[0] = X_reg1;
  assign x_in[1] = X_reg2;
  assign x_in[2] = X_reg3;
  assign x_in[3] = X_reg4;

  assign result1 = res_q[0];
  assign result2 = res_q[1];
  assign result3 = res_q[2];
  assign result4 = res_q[3];

  // Sequencer: walks k through the inner product and col through the columns.
  // coef_addr leads the stage-1 capture by one cycle so ROM data and x_q meet in stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      col          <= '0;
      k            <= '0;
      X_shift      <= 1'b0;
      coef_addr    <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && xload_done) begin
            state     <= MAC;
            col       <= '0;
            k         <= '0;
            X_shift   <= 1'b1;
            coef_addr <= '0;
            busy      <= 1'b1;
          end
        end
        MAC: begin
          if (k == LAST_K) begin
            state   <= DRAIN;
            k       <= '0;
            X_shift <= 1'b0;
          end else begin
            k         <= k + 1'b1;
            coef_addr <= {col, k + 1'b1};
          end
        end
        DRAIN: begin
          // acc_next already includes the final product, so results are ready next cycle
          state        <= OUT;
          result_valid <= 1'b1;
          for (int i = 0; i < 4; i++) res_q[i] <= acc_next[i];
        end
        OUT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (col == LAST_COL) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state     <= MAC;
              col       <= col + 1'b1;
              X_shift   <= 1'b1;
              coef_addr <= {col + 1'b1, K_W'(0)};
            end
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: capture the lane heads while the buffer is being shifted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid <= 1'b0;
      first_q <= 1'b0;
      for (int i = 0; i < 4; i++) x_q[i] <= '0;
    end else begin
      p_valid <= (state == MAC);
      first_q <= (k == '0);
      if (state == MAC) begin
        for (int i = 0; i < 4; i++) x_q[i] <= x_in[i];
      end
    end
  end

  // Stage 2 arithmetic: unsigned product, restart or accumulate.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      prod[i]     = {{DATA_W{1'b0}}, x_q[i]} * {{DATA_W{1'b0}}, coef_data};
      acc_next[i] = acc[i];
      if (p_valid) begin
        acc_next[i] = first_q ? ACC_W'(prod[i]) : acc[i] + ACC_W'(prod[i]);
      end
    end
  end

  // Stage 2 register: accumulators track acc_next whenever a product is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
    end else if (p_valid) begin
      for (int i = 0; i < 4; i++) acc[i] <= acc_next[i];
    end
  end

endmodule
